// File: rtl/axi4_reg_target.sv
// AXI4 single-beat subordinate: turns AW/W/AR into one register-port access, with window decode, alignment check and timeout.
// Latency: handshake N -> reg_req N+1 -> b_valid/r_valid N+2 when reg_ack comes at once.
// Backpressure: one transaction in flight; every ready stays low until the B/R response is taken.
module axi4_reg_target #(
    parameter int              ALEN    = 32,
    parameter int              XLEN    = 32,
    parameter int              IDLEN   = 5,
    parameter logic [ALEN-1:0] REGMAP  = 32'h1_0000,
    parameter int unsigned     REGSPAN = 32'h100,
    parameter int              TIMEOUT = 16,
    localparam int             OFFW    = $clog2(REGSPAN),
    localparam int             SW      = XLEN / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ALEN-1:0]  aw_addr,
    input  logic [IDLEN-1:0] aw_id,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic [XLEN-1:0]  w_data,
    input  logic [SW-1:0]    w_strb,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [IDLEN-1:0] b_id,
    output logic [1:0]       b_resp,
    output logic             b_valid,
    input  logic             b_ready,
    input  logic [ALEN-1:0]  ar_addr,
    input  logic [IDLEN-1:0] ar_id,
    input  logic             ar_valid,
    output logic             ar_ready,
    output logic [XLEN-1:0]  r_data,
    output logic [IDLEN-1:0] r_id,
    output logic [1:0]       r_resp,
    output logic             r_last,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             reg_req,
    output logic             reg_we,
    output logic [OFFW-1:0]  reg_addr,
    output logic [XLEN-1:0]  reg_wdata,
    output logic [SW-1:0]    reg_wstrb,
    input  logic [XLEN-1:0]  reg_rdata,
    input  logic             reg_ack,
    input  logic             reg_err
);
    typedef enum logic [2:0] {IDLE, WDATA, WADDR, WACC, BRESP, RACC, RRESP} state_t;

    typedef struct packed {
        logic [ALEN-1:0]  addr;
        logic [IDLEN-1:0] id;
        logic [XLEN-1:0]  wdata;
        logic [SW-1:0]    wstrb;
    } hdr_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int         CW     = $clog2(TIMEOUT + 1);

    state_t          state, nxt;
    hdr_t            hdr_q;
    logic            prio_w;
    logic [1:0]      resp_q;
    logic [XLEN-1:0] rdata_q;
    logic [CW-1:0]   cnt;
    logic            wr_req, grant_w, grant_r, acc, expired;
    logic [ALEN-1:0] off;
    logic [1:0]      dec_resp;

    // A lone AW or W only competes for the bus when no read is waiting.
    assign wr_req  = (aw_valid && w_valid) || ((aw_valid || w_valid) && !ar_valid);
    assign grant_w = wr_req && (prio_w || !ar_valid);
    assign grant_r = ar_valid && !grant_w;
    assign acc     = (state == WACC) || (state == RACC);
    assign off     = hdr_q.addr - REGMAP;
    assign expired = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        if (off >= ALEN'(REGSPAN))
            dec_resp = DECERR;
        else if (hdr_q.addr[1:0] != 2'b00)
            dec_resp = SLVERR;
        else
            dec_resp = OKAY;
    end

    always_comb begin
        nxt      = state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        ar_ready = 1'b0;
        reg_req  = 1'b0;
        case (state)
            IDLE: begin
                aw_ready = grant_w;
                w_ready  = grant_w;
                ar_ready = grant_r;
                if (grant_w)
                    nxt = (aw_valid && w_valid) ? WACC : (aw_valid ? WDATA : WADDR);
                else if (grant_r)
                    nxt = RACC;
            end
            WDATA: begin
                w_ready = 1'b1;
                if (w_valid) nxt = WACC;
            end
            WADDR: begin
                aw_ready = 1'b1;
                if (aw_valid) nxt = WACC;
            end
            WACC, RACC: begin
                if (dec_resp != OKAY) begin
                    nxt = (state == WACC) ? BRESP : RRESP;
                end else begin
                    reg_req = 1'b1;
                    if (reg_ack || expired) nxt = (state == WACC) ? BRESP : RRESP;
                end
            end
            BRESP:   if (b_ready) nxt = IDLE;
            RRESP:   if (r_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio_w  <= 1'b1;
            hdr_q   <= '0;
            resp_q  <= OKAY;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            if (aw_ready && aw_valid) begin
                hdr_q.addr <= aw_addr;
                hdr_q.id   <= aw_id;
            end
            if (w_ready && w_valid) begin
                hdr_q.wdata <= w_data;
                hdr_q.wstrb <= w_strb;
            end
            if (ar_ready && ar_valid) begin
                hdr_q.addr <= ar_addr;
                hdr_q.id   <= ar_id;
            end
            // Read data defaults to zero so decode errors and timeouts return nothing stale.
            if (state == IDLE && (grant_w || grant_r)) begin
                prio_w  <= !prio_w;
                rdata_q <= '0;
            end
            cnt <= acc ? cnt + 1'b1 : '0;
            if (acc) begin
                if (dec_resp != OKAY) begin
                    resp_q <= dec_resp;
                end else if (reg_ack) begin
                    resp_q <= reg_err ? SLVERR : OKAY;
                    if (state == RACC) rdata_q <= reg_rdata;
                end else if (expired) begin
                    resp_q <= SLVERR;
                end
            end
        end
    end

    assign reg_we    = (state == WACC);
    assign reg_addr  = acc ? off[OFFW-1:0] : '0;
    assign reg_wdata = hdr_q.wdata;
    assign reg_wstrb = hdr_q.wstrb;
    assign b_valid   = (state == BRESP);
    assign r_valid   = (state == RRESP);
    assign r_last    = r_valid;
    assign b_id      = hdr_q.id;
    assign r_id      = hdr_q.id;
    assign b_resp    = resp_q;
    assign r_resp    = resp_q;
    assign r_data    = rdata_q;
endmodule

// File: tb/tb_axi4_reg_target.sv
// Bench for axi4_reg_target: directed and random single-beat transactions against a register-file model.
module tb_axi4_reg_target;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] REGMAP  = 32'h1_0000;
    localparam logic [31:0] REGSPAN = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aw_addr, w_data, ar_addr, r_data, reg_wdata, reg_rdata;
    logic [4:0]  aw_id, b_id, ar_id, r_id;
    logic [3:0]  w_strb, reg_wstrb;
    logic [1:0]  b_resp, r_resp;
    logic [7:0]  reg_addr;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic        reg_req, reg_we, reg_ack, reg_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [31:0] mem [64];
    bit prio_w = 1'b1;

    axi4_reg_target dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_id(aw_id), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        b_ready  = 1'b0; r_ready = 1'b0; reg_ack = 1'b0; reg_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        prio_w = 1'b1;
        #1;
        chk("rst_ctrl", {aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last, reg_req, reg_we,
                         b_id, r_id, b_resp, r_resp, reg_wstrb}, 32'h0);
        chk("rst_reg_addr", reg_addr, 32'h0);
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_reg_wdata", reg_wdata, 32'h0);
    endtask

    // split: 0 AW+W together, >0 W follows AW by split cycles, <0 AW follows W. ack_dly<0: never ack.
    task automatic xact(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [4:0] id, input int split,
                        input int ack_dly, input int rdy_dly, input bit err);
        logic [31:0] off, exp_rdata, snap_d;
        logic [12:0] snap;
        logic [1:0]  exp_resp;
        logic [8:0]  obs, expv;
        bit          in_win, dec_ok, acked, stable, early;
        int          idx, exp_len, resp_at, req_len, gap;
        off     = addr - REGMAP;
        in_win  = (off < REGSPAN);
        dec_ok  = in_win && (addr[1:0] == 2'b00);
        acked   = dec_ok && (ack_dly >= 0) && (ack_dly < TIMEOUT);
        idx     = int'(off[7:2]);
        if (!in_win)                      exp_resp = 2'b11;
        else if (!dec_ok || !acked || err) exp_resp = 2'b10;
        else                              exp_resp = 2'b00;
        exp_rdata = (!is_wr && acked) ? mem[idx] : 32'h0;
        exp_len   = acked ? ack_dly + 1 : (dec_ok ? TIMEOUT : 0);
        resp_at   = dec_ok ? exp_len + 1 : 2;
        gap       = (is_wr && split != 0) ? ((split < 0) ? -split : split) : 0;
        snap      = '0;
        snap_d    = '0;

        @(negedge clk);
        if (is_wr) begin
            aw_addr = addr; aw_id = id; w_data = data; w_strb = strb;
            aw_valid = (split >= 0); w_valid = (split <= 0);
            #1 chk("wr_accept", (split >= 0) ? aw_ready : w_ready, 32'h1);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b1; ar_addr = REGMAP;
                #1 chk("split_wait_rdy", {((split > 0) ? w_ready : aw_ready), ar_ready}, 32'h2);
            end
            if (gap != 0) begin
                @(negedge clk);
                ar_valid = 1'b0; aw_valid = (split < 0); w_valid = (split > 0);
                #1 chk("split_accept", (split > 0) ? w_ready : aw_ready, 32'h1);
            end
        end else begin
            ar_addr = addr; ar_id = id; ar_valid = 1'b1;
            #1 chk("rd_accept", ar_ready, 32'h1);
        end
        prio_w = !prio_w;

        req_len = 0; stable = 1'b1; early = 1'b0;
        for (int c = 1; c < resp_at; c++) begin
            @(negedge clk);
            aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
            reg_ack   = acked && (c == ack_dly + 1);
            reg_err   = err;
            reg_rdata = reg_ack ? mem[idx] : $urandom;
            #1;
            if (reg_req) req_len++;
            if (b_valid || r_valid) early = 1'b1;
            if (c == 1) begin
                chk("req_first", reg_req, dec_ok);
                if (dec_ok) begin
                    chk("reg_we", reg_we, is_wr);
                    chk("reg_addr", reg_addr, off[7:0]);
                    if (is_wr) begin
                        chk("reg_wdata", reg_wdata, data);
                        chk("reg_wstrb", reg_wstrb, strb);
                    end
                end
                snap = {reg_we, reg_addr, reg_wstrb};
                snap_d = reg_wdata;
            end else if ({reg_we, reg_addr, reg_wstrb} !== snap || reg_wdata !== snap_d) begin
                stable = 1'b0;
            end
            if (reg_ack && is_wr)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        chk("req_len", req_len, exp_len);
        chk("no_early_resp", early, 32'h0);
        if (dec_ok) chk("reg_stable", stable, 32'h1);

        stable = 1'b1;
        for (int c = 0; c <= rdy_dly; c++) begin
            @(negedge clk);
            reg_ack = 1'b0; reg_rdata = $urandom;
            aw_valid = (c < rdy_dly); w_valid = (c < rdy_dly); ar_valid = (c < rdy_dly);
            b_ready = is_wr && (c == rdy_dly);
            r_ready = !is_wr && (c == rdy_dly);
            #1;
            if (is_wr) begin
                obs  = {b_valid, r_valid, b_id, b_resp};
                expv = {1'b1, 1'b0, id, exp_resp};
            end else begin
                obs  = {r_valid, b_valid, r_id, r_resp};
                expv = {1'b1, 1'b0, id, exp_resp};
            end
            if (c == 0) begin
                if (is_wr) chk("b_chan", obs, expv);
                else       chk("r_chan", obs, expv);
                if (!is_wr) begin
                    chk("r_last", r_last, 32'h1);
                    if (dec_ok) chk("r_data", r_data, exp_rdata);
                end
                if (rdy_dly > 0) chk("stall_rdy", {aw_ready, w_ready, ar_ready}, 32'h0);
            end else if (obs !== expv || (!is_wr && dec_ok && r_data !== exp_rdata)) begin
                stable = 1'b0;
            end
        end
        if (rdy_dly > 0) chk("resp_hold", stable, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1 chk("resp_done", {b_valid, r_valid}, 32'h0);
    endtask

    initial begin
        int          r, ack;
        logic [31:0] a;
        logic [1:0]  got, want;
        bit          quiet;
        rst = 1'b1;
        aw_addr = '0; aw_id = '0; w_data = '0; w_strb = '0;
        ar_addr = '0; ar_id = '0; reg_rdata = '0;
        idle_inputs();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5] = 32'h2;
        do_reset();

        xact(1'b1, 32'h1_0000, 32'hA2C, 4'hF, 5'd3, 0, 0, 0, 1'b0);
        xact(1'b0, 32'h1_0014, 32'h0, 4'h0, 5'd7, 0, 2, 3, 1'b0);
        xact(1'b1, 32'h1_001C, 32'h20, 4'hF, 5'd1, 3, 0, 0, 1'b0);
        xact(1'b0, 32'h1_001C, 32'h0, 4'h0, 5'd9, 0, 1, 0, 1'b0);
        xact(1'b1, 32'h2_0000, 32'h1, 4'hF, 5'd2, 0, 0, 0, 1'b0);
        xact(1'b0, 32'h1_0012, 32'h0, 4'h0, 5'd4, 0, 0, 0, 1'b0);
        xact(1'b0, 32'h1_0004, 32'h0, 4'h0, 5'd5, 0, -1, 0, 1'b0);
        xact(1'b1, 32'h1_0008, 32'h1234_5678, 4'h5, 5'd6, -2, 1, 1, 1'b1);
        xact(1'b0, 32'h1_0008, 32'h0, 4'h0, 5'd8, 0, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 15));
            a = REGMAP + 32'($urandom_range(0, 7)) * 32'd4;
            if (r == 0)      a = 32'h2_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            else if (r == 1) a = a + 32'($urandom_range(1, 3));
            ack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 5'($urandom_range(0, 31)), int'($urandom_range(0, 4)) - 2, ack,
                 int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
        end

        // Contention with every channel always valid: grants alternate, one per 3 cycles.
        do_reset();
        @(negedge clk);
        aw_addr = 32'h1_0008; aw_id = 5'd1; w_data = 32'hCAFE; w_strb = 4'hF;
        ar_addr = 32'h1_000C; ar_id = 5'd2; reg_rdata = 32'h55;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        reg_ack = 1'b1; reg_err = 1'b0; b_ready = 1'b1; r_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            got = (aw_ready && aw_valid) ? 2'd1 : (ar_ready ? 2'd2 : 2'd0);
            if (c % 3 == 0) begin
                want = prio_w ? 2'd1 : 2'd2;
                prio_w = !prio_w;
            end else begin
                want = 2'd0;
            end
            chk("arb_grant", got, want);
        end
        @(negedge clk);
        idle_inputs();
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1 chk("lone_aw_vs_ar", {aw_ready, w_ready, ar_ready}, 32'h1);
        aw_valid = 1'b0; ar_valid = 1'b0;

        @(negedge clk);
        aw_addr = 32'h1_0010; w_data = 32'h77; aw_valid = 1'b1; w_valid = 1'b1;
        #1 chk("rst_wr_accept", aw_ready, 32'h1);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        #1 chk("rst_in_wacc", reg_req, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prio_w = 1'b1;
        #1 chk("rst_req_drop", {reg_req, b_valid, r_valid}, 32'h0);
        ar_valid = 1'b1;
        #1 chk("rst_idle", ar_ready, 32'h1);
        ar_valid = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (b_valid || r_valid || reg_req) quiet = 1'b0;
        end
        chk("rst_no_resp", quiet, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/axi4_reg_target.md
Name: axi4_reg_target

Overview:
AXI4 single-beat subordinate that terminates the bus on the peripheral side, such as behind the UART register map. It accepts AW/W/AR requests from an initiator and converts each into one access on a simple register port. It then returns B or R responses, with address-window decode, alignment checks and an access timeout. Bursts are not supported; every transaction is one beat.

Parameters:
ALEN, 32, address width
XLEN, 32, data width (strobe width XLEN/8)
IDLEN, 5, transaction ID width
REGMAP, 32'h1_0000, window base address
REGSPAN, 32'h100, window size in bytes (power of 2); OFFW = $clog2(REGSPAN)
TIMEOUT, 16, cycles a register access may wait for reg_ack before it is aborted

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
aw_addr  in  ALEN  write address
aw_id  in  IDLEN  write ID
aw_valid  in  1  write address valid
aw_ready  out  1  write address accepted
w_data  in  XLEN  write data
w_strb  in  XLEN/8  byte strobes
w_valid  in  1  write data valid
w_ready  out  1  write data accepted
b_id  out  IDLEN  echoed aw_id
b_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
b_valid  out  1  write response valid
b_ready  in  1  write response taken
ar_addr  in  ALEN  read address
ar_id  in  IDLEN  read ID
ar_valid  in  1  read address valid
ar_ready  out  1  read address accepted
r_data  out  XLEN  read data
r_id  out  IDLEN  echoed ar_id
r_resp  out  2  as b_resp
r_last  out  1  always 1 while r_valid
r_valid  out  1  read data valid
r_ready  in  1  read data taken
reg_req  out  1  register access request
reg_we  out  1  1 write, 0 read
reg_addr  out  OFFW  byte offset = addr - REGMAP
reg_wdata  out  XLEN  write data
reg_wstrb  out  XLEN/8  byte strobes
reg_rdata  in  XLEN  read data, valid with reg_ack
reg_ack  in  1  access complete
reg_err  in  1  access error, qualified by reg_ack

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE; prio=write; every valid/ready/req output is 0; b_resp, r_resp, r_data, ids, reg_* buses are 0. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, WDATA (AW held, W pending), WADDR (W held, AW pending), WACC, BRESP, RACC, RRESP.
- IDLE:
  - aw_ready=w_ready=1 when the write is granted; ar_ready=1 when the read is granted.
  - Grant when both requests are valid goes to prio; prio toggles after each granted transaction.
  - A write channel with only one of aw/w valid counts as a write request only when no read is valid.
- Write path:
  - Both AW and W handshake in one cycle -> WACC.
  - AW only -> WDATA, where w_ready=1 until W arrives -> WACC.
  - W only -> WADDR, where aw_ready=1 until AW arrives -> WACC.
  - ar_ready is 0 throughout.
- Decode at entry to WACC/RACC:
  - Outside [REGMAP, REGMAP+REGSPAN) -> resp 11, no reg_req.
  - addr[1:0]!=0 -> resp 10, no reg_req.
  - In both cases go directly to BRESP/RRESP on the next cycle.
- WACC/RACC:
  - reg_req=1 and reg_addr/we/wdata/wstrb stay stable until reg_ack.
  - reg_ack may come in the first reg_req cycle.
  - On reg_ack: capture resp = reg_err ? 10 : 00 and capture reg_rdata (read), drop reg_req, then go to BRESP/RRESP.
  - A cycle counter starts at 0 on entry. If it reaches TIMEOUT-1 without reg_ack: drop reg_req, resp=10, r_data=0.
- BRESP/RRESP:
  - b_valid/r_valid=1 with id/resp/data held stable until b_ready/r_ready.
  - On that handshake -> IDLE.
  - Upstream stays stalled (all readys 0) while a response is pending.
- Latency (no stalls, immediate reg_ack): handshake cycle N -> reg_req at N+1 -> b_valid/r_valid at N+2. Back-to-back transactions take 3 cycles each.
- Exactly one outstanding transaction at any time.

Test Plan:
- Write aw_addr=0x1_0000, w_data=0xA2C, strb=0xF, aw_id=3, same cycle; reg_ack immediate -> reg_req at N+1 with reg_we=1, reg_addr=0x00, reg_wdata=0xA2C; b_valid at N+2, b_id=3, b_resp=00.
- Read ar_addr=0x1_0014, ar_id=7; reg_rdata=0x2 with reg_ack 2 cycles after reg_req; r_ready held 0 for 3 cycles -> r_valid and r_data=0x2 stay stable; r_id=7, r_last=1, r_resp=00.
- AW to 0x1_001C, W (0x20) 3 cycles later -> w_ready=1 and ar_ready=0 meanwhile; reg_addr=0x1C, reg_wdata=0x20, b_resp=00.
- Write to 0x2_0000 -> b_resp=11, no reg_req. Read 0x1_0012 -> r_resp=10, no reg_req.
- Read 0x1_0004 with reg_ack never asserted -> reg_req drops after 16 cycles; r_resp=10, r_data=0.
- AW+W and AR all valid every cycle with responses taken immediately -> grant order write, read, write, read. Assert rst during a WACC -> next cycle reg_req=0, state IDLE, no b_valid.
